// File: rtl/in_arb_monitor_regs_if.sv
// Register-ring bus bundle shared by the input-arbiter monitor and its ring neighbours.

`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif
`ifndef IN_ARB_BLOCK_ADDR
`define IN_ARB_BLOCK_ADDR 17'h00002
`endif

interface in_arb_monitor_regs_if #(
  parameter int ADDR_WIDTH = `UDP_REG_ADDR_WIDTH,
  parameter int DATA_WIDTH = `CPCI_NF2_DATA_WIDTH,
  parameter int SRC_WIDTH  = 2
);
  logic                  reg_req;
  logic                  reg_ack;
  logic                  reg_rd_wr_L;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [DATA_WIDTH-1:0] reg_data;
  logic [SRC_WIDTH-1:0]  reg_src;

  modport master (
    output reg_req, reg_ack, reg_rd_wr_L, reg_addr, reg_data, reg_src
  );

  modport slave (
    input reg_req, reg_ack, reg_rd_wr_L, reg_addr, reg_data, reg_src
  );
endinterface

// File: rtl/in_arb_monitor_regs.sv
// Input-arbiter monitor: packet/word counters, arbiter state latch and a
// capture buffer holding the first words of a packet, exposed on the register ring.

`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif
`ifndef IN_ARB_BLOCK_ADDR
`define IN_ARB_BLOCK_ADDR 17'h00002
`endif

module in_arb_monitor_regs #(
  parameter int DATA_WIDTH        = 64,
  parameter int CTRL_WIDTH        = DATA_WIDTH / 8,
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int NUM_CAPTURE_WORDS = 4,
  parameter int STATE_WIDTH       = 3,
  parameter int REG_ADDR_WIDTH    = 6,
  parameter logic [`UDP_REG_ADDR_WIDTH-REG_ADDR_WIDTH-1:0] BLOCK_TAG = `IN_ARB_BLOCK_ADDR
) (
  input  logic                   clk,
  input  logic                   reset,
  in_arb_monitor_regs_if.slave   i_ring,
  in_arb_monitor_regs_if.master  o_ring,
  input  logic [STATE_WIDTH-1:0] state,
  input  logic                   out_wr,
  input  logic                   out_rdy,
  input  logic                   eop,
  input  logic [CTRL_WIDTH-1:0]  out_ctrl,
  input  logic [DATA_WIDTH-1:0]  out_data
);

  localparam int UAW      = `UDP_REG_ADDR_WIDTH;
  localparam int DWORDS   = DATA_WIDTH / 32;
  localparam int NUM_REGS = 8 + 4 * NUM_CAPTURE_WORDS;

  logic                         r_freeze, r_clrOnRd, r_oneshot, r_armed, r_oneshotDone;
  logic                         r_inPkt, r_capActive;
  logic [15:0]                  r_wordIdx, r_lastLen;
  logic [31:0]                  r_numPkts, r_numWords;
  logic [STATE_WIDTH-1:0]       r_stateLatched;
  logic                         r_outRdyLatched;
  logic [DATA_WIDTH-1:0]        r_slotData [NUM_CAPTURE_WORDS];
  logic [CTRL_WIDTH-1:0]        r_slotCtrl [NUM_CAPTURE_WORDS];

  logic                         w_tagHit, w_access, w_addrValid, w_ctrlWrite, w_pktClear;
  logic [31:0]                  w_offset, w_rdData;
  logic [UDP_REG_SRC_WIDTH-1:0] w_src;
  logic                         w_firstWord, w_lastWord, w_capEnable;
  logic                         w_capStart, w_slotLoad, w_capEnd;
  logic [15:0]                  w_idxInc;

  assign w_tagHit    = (i_ring.reg_addr[UAW-1:REG_ADDR_WIDTH] == BLOCK_TAG);
  assign w_access    = i_ring.reg_req && w_tagHit;
  assign w_offset    = 32'(i_ring.reg_addr[REG_ADDR_WIDTH-1:0]);
  assign w_addrValid = (w_offset < 32'(NUM_REGS));
  assign w_ctrlWrite = w_access && !i_ring.reg_rd_wr_L && w_addrValid && (w_offset == 32'd2);
  assign w_pktClear  = w_access && (w_offset == 32'd0) && r_clrOnRd;
  assign w_src       = i_ring.reg_src;

  assign w_firstWord = !r_inPkt && (out_ctrl == '0);
  assign w_lastWord  = r_inPkt && (out_ctrl != '0);
  assign w_idxInc    = (r_wordIdx == 16'hFFFF) ? r_wordIdx : r_wordIdx + 16'd1;
  assign w_capEnable = !r_freeze && (!r_oneshot || r_armed);
  assign w_capStart  = out_wr && w_firstWord && w_capEnable;
  assign w_slotLoad  = out_wr && r_inPkt && r_capActive && !r_freeze;
  assign w_capEnd    = out_wr && w_lastWord && r_capActive;

  // Track packet boundaries and the 1-based index of the current word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inPkt   <= 1'b0;
      r_wordIdx <= 16'd0;
    end else if (out_wr) begin
      if (w_firstWord) begin
        r_inPkt   <= 1'b1;
        r_wordIdx <= 16'd1;
      end else if (r_inPkt) begin
        r_wordIdx <= w_idxInc;
        if (out_ctrl != '0) r_inPkt <= 1'b0;
      end
    end
  end

  // Fill capture slots: a new capture clears stale words, later words fill their own slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUM_CAPTURE_WORDS; s++) begin
        r_slotData[s] <= '0;
        r_slotCtrl[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_CAPTURE_WORDS; s++) begin
        if (w_capStart) begin
          r_slotData[s] <= (s == 0) ? out_data : '0;
          r_slotCtrl[s] <= (s == 0) ? out_ctrl : '0;
        end else if (w_slotLoad && (r_wordIdx == 16'(s))) begin
          r_slotData[s] <= out_data;
          r_slotCtrl[s] <= out_ctrl;
        end
      end
    end
  end

  // Control register, one-shot arming and capture bookkeeping; an arm write overrides completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_freeze      <= 1'b0;
      r_clrOnRd     <= 1'b1;
      r_oneshot     <= 1'b0;
      r_armed       <= 1'b0;
      r_oneshotDone <= 1'b0;
      r_capActive   <= 1'b0;
      r_lastLen     <= 16'd0;
    end else begin
      if (w_capStart) r_capActive <= 1'b1;
      if (w_capEnd) begin
        r_capActive <= 1'b0;
        r_lastLen   <= w_idxInc;
        if (r_oneshot) begin
          r_armed       <= 1'b0;
          r_oneshotDone <= 1'b1;
        end
      end
      if (w_ctrlWrite) begin
        r_freeze  <= i_ring.reg_data[0];
        r_clrOnRd <= i_ring.reg_data[1];
        r_oneshot <= i_ring.reg_data[2];
        if (i_ring.reg_data[3]) begin
          r_armed       <= 1'b1;
          r_oneshotDone <= 1'b0;
        end
      end
    end
  end

  // Free-running counters and arbiter state latch, unaffected by freeze.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_numPkts       <= 32'd0;
      r_numWords      <= 32'd0;
      r_stateLatched  <= '0;
      r_outRdyLatched <= 1'b0;
    end else begin
      if (w_pktClear)  r_numPkts <= 32'(eop);
      else if (eop)    r_numPkts <= r_numPkts + 32'd1;
      if (out_wr && (r_numWords != 32'hFFFF_FFFF)) r_numWords <= r_numWords + 32'd1;
      r_stateLatched  <= state;
      r_outRdyLatched <= out_rdy;
    end
  end

  // Read mux over the register map; out-of-range offsets return a marker value.
  always_comb begin
    w_rdData = 32'd0;
    if (!w_addrValid) begin
      w_rdData = 32'hDEAD_BEEF;
    end else begin
      case (w_offset)
        32'd0:   w_rdData = r_numPkts;
        32'd1:   w_rdData = 32'({r_outRdyLatched, r_stateLatched});
        32'd2:   w_rdData = {28'd0, 1'b0, r_oneshot, r_clrOnRd, r_freeze};
        32'd3:   w_rdData = r_numWords;
        32'd4:   w_rdData = 32'(r_lastLen);
        32'd5:   w_rdData = 32'(r_oneshotDone);
        default: w_rdData = 32'd0;
      endcase
      for (int s = 0; s < NUM_CAPTURE_WORDS; s++) begin
        for (int k = 0; k < DWORDS; k++) begin
          if (w_offset == 32'(8 + 4 * s + k)) w_rdData = r_slotData[s][32*k +: 32];
        end
        if (w_offset == 32'(8 + 4 * s + 3)) w_rdData = 32'(r_slotCtrl[s]);
      end
    end
  end

  // Registered ring stage: answer hits, pass everything else through one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_ring.reg_req     <= 1'b0;
      o_ring.reg_ack     <= 1'b0;
      o_ring.reg_rd_wr_L <= 1'b0;
      o_ring.reg_addr    <= '0;
      o_ring.reg_data    <= '0;
      o_ring.reg_src     <= '0;
    end else begin
      o_ring.reg_req     <= i_ring.reg_req;
      o_ring.reg_rd_wr_L <= i_ring.reg_rd_wr_L;
      o_ring.reg_addr    <= i_ring.reg_addr;
      o_ring.reg_src     <= w_src;
      o_ring.reg_ack     <= w_access ? 1'b1 : i_ring.reg_ack;
      o_ring.reg_data    <= (w_access && i_ring.reg_rd_wr_L) ? w_rdData : i_ring.reg_data;
    end
  end

endmodule
